// File: rtl/expu_pkg.sv
// expu_pkg
// Shared definitions for the exp/log units of the softmax datapath.
// Contents:
//   fp_format_e    - supported float formats
//   log_class_e    - operand classes seen by the log unit
//   exp_bits/man_bits/fp_width          - float format geometry
//   fix_frac_bits/fix_mag_bits          - fixed-point widths used by the log unit
//   pos_inf/neg_inf/canonical_nan       - special bit patterns, LSB-aligned in 64 bits
package expu_pkg;

  typedef enum logic [2:0] {
    FP32,
    FP64,
    FP16,
    FP8,
    FP16ALT
  } fp_format_e;

  typedef enum logic [2:0] {
    NORMAL,
    ZERO,
    NEG,
    INF,
    NAN
  } log_class_e;

  function automatic int unsigned exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 7;
    endcase
  endfunction

  function automatic int unsigned fp_width(input fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // Fraction bits of the fixed-point log value: the mantissa plus guard bits.
  function automatic int unsigned fix_frac_bits(input fp_format_e fmt, input int unsigned guard);
    return man_bits(fmt) + guard;
  endfunction

  // Total magnitude width: the integer part needs as many bits as the exponent field.
  function automatic int unsigned fix_mag_bits(input fp_format_e fmt, input int unsigned guard);
    return exp_bits(fmt) + man_bits(fmt) + guard;
  endfunction

  function automatic logic [63:0] pos_inf(input fp_format_e fmt);
    logic [63:0] ones;
    ones = (64'd1 << exp_bits(fmt)) - 64'd1;
    return ones << man_bits(fmt);
  endfunction

  function automatic logic [63:0] neg_inf(input fp_format_e fmt);
    return pos_inf(fmt) | (64'd1 << (exp_bits(fmt) + man_bits(fmt)));
  endfunction

  // Quiet NaN with positive sign and only the mantissa MSB set.
  function automatic logic [63:0] canonical_nan(input fp_format_e fmt);
    return pos_inf(fmt) | (64'd1 << (man_bits(fmt) - 1));
  endfunction

endpackage

// File: rtl/logu_lzc.sv
// logu_lzc
// Parametric leading-zero counter used to renormalise fixed-point values.
// Ports:
//   value  in  WIDTH      word to scan
//   count  out CNT_WIDTH  number of zeros above the most significant one (WIDTH when value is 0)
//   empty  out 1          value is all zeros
module logu_lzc #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     value,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty
);

  // Scan from the LSB upwards so the highest set bit is the last one to
  // overwrite the count, leaving the distance from that bit to the MSB.
  always_comb begin
    count = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (value[i]) begin
        count = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end
  end

  assign empty = (value == '0);

endmodule

// File: rtl/logu_log2.sv
// logu_log2
// Three-stage pipelined base-2 logarithm for positive floats.
// Stage 1 unpacks and classifies, stage 2 turns the mantissa into log2(1+m)
// with a quadratic correction and adds the unbiased exponent, stage 3
// renormalises the fixed-point magnitude back into the float format.
// Ports:
//   clk_i    in  1      clock
//   rst_i    in  1      asynchronous active-high reset
//   valid_i  in  1      operand valid
//   ready_o  out 1      unit accepts op_i this cycle
//   op_i     in  WIDTH  float operand
//   valid_o  out 1      result valid
//   ready_i  in  1      downstream accepts res_o
//   res_o    out WIDTH  float log2(op_i)
module logu_log2
  import expu_pkg::*;
#(
  parameter fp_format_e   FPFORMAT             = FP16ALT,
  parameter int unsigned  COEFFICIENT_FRACTION = 5,
  parameter real          K_REAL               = 0.34375,
  parameter int unsigned  GUARD_BITS           = 3,
  localparam int unsigned WIDTH                = fp_width(FPFORMAT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] res_o
);

  localparam int unsigned E          = exp_bits(FPFORMAT);
  localparam int unsigned M          = man_bits(FPFORMAT);
  localparam int unsigned F          = fix_frac_bits(FPFORMAT, GUARD_BITS);
  localparam int unsigned VW         = fix_mag_bits(FPFORMAT, GUARD_BITS);
  localparam int unsigned CW         = $clog2(VW + 1);
  localparam int unsigned BIAS       = (2 ** (E - 1)) - 1;
  localparam int unsigned KW         = COEFFICIENT_FRACTION + 2;
  localparam int unsigned PROD_W     = 2 * M + 1 + KW;
  // m*(1-m) carries 2M fraction bits and K adds its own; drop down to F.
  localparam int unsigned SHIFT      = M + COEFFICIENT_FRACTION - GUARD_BITS;
  // Exponent of a value whose leading one sits at bit (VW-1) of the magnitude.
  localparam int unsigned EXP_OFFSET = BIAS + VW - 1 - F;
  localparam int          K_INT      = int'(K_REAL * real'(2 ** COEFFICIENT_FRACTION));
  localparam logic [KW-1:0]    K_VEC       = KW'(K_INT);
  localparam logic [WIDTH-1:0] NAN_PAT     = WIDTH'(canonical_nan(FPFORMAT));
  localparam logic [WIDTH-1:0] POS_INF_PAT = WIDTH'(pos_inf(FPFORMAT));
  localparam logic [WIDTH-1:0] NEG_INF_PAT = WIDTH'(neg_inf(FPFORMAT));

  // Handshake state
  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;

  // Stage 1 registers
  logic [E-1:0] s1_exp;
  logic [M-1:0] s1_man;
  log_class_e   s1_class;

  // Stage 2 registers
  logic [VW-1:0] s2_mag;
  logic          s2_neg;
  log_class_e    s2_class;

  // Stage 3 register
  logic [WIDTH-1:0] s3_res;

  // Combinational stage inputs
  logic [E-1:0]          in_exp;
  logic [M-1:0]          in_man;
  log_class_e            in_class;
  logic signed [E+1:0]   k_int;
  logic                  k_neg;
  logic [E-1:0]          k_abs;
  logic [M:0]            one_minus;
  logic [PROD_W-1:0]     prod;
  logic [F:0]            f_sum;
  logic [F-1:0]          f_frac;
  logic [VW-1:0]         int_part;
  logic [VW-1:0]         mag_next;
  logic [CW-1:0]         lz_count;
  logic                  mag_zero;
  logic [E-1:0]          norm_exp;
  logic [M-1:0]          norm_mant;
  logic [WIDTH-1:0]      packed_res;
  logic [WIDTH-1:0]      res_next;

  // A stage can take new data when it is empty or its content moves on this
  // cycle; the chain is combinational so a free output slot propagates back
  // to the input in the same cycle.
  assign s3_ready = ~s3_valid | ready_i;
  assign s2_ready = ~s2_valid | s3_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign ready_o  = s1_ready;
  assign valid_o  = s3_valid;
  assign res_o    = s3_res;

  // Split the operand and decide its class. Zero exponents (zero and
  // denormals) flush to zero and win over the sign, so -0 also gives -inf.
  always_comb begin
    in_exp   = op_i[WIDTH-2 -: E];
    in_man   = op_i[M-1:0];
    in_class = NORMAL;
    if (in_exp == '0) begin
      in_class = ZERO;
    end else if (op_i[WIDTH-1]) begin
      in_class = NEG;
    end else if (in_exp == '1) begin
      in_class = (in_man == '0) ? INF : NAN;
    end
  end

  // Correction: f = m + K*m*(1-m) in Q0.F with the product truncated, then
  // combine with the unbiased exponent k. For negative k the magnitude is
  // |k| - f, which stays positive because |k| >= 1 > f.
  always_comb begin
    k_int     = $signed({2'b00, s1_exp}) - $signed((E + 2)'(BIAS));
    k_neg     = k_int[E+1];
    k_abs     = k_neg ? E'(-k_int) : E'(k_int);
    one_minus = {1'b1, {M{1'b0}}} - {1'b0, s1_man};
    prod      = PROD_W'(s1_man) * PROD_W'(one_minus) * PROD_W'(K_VEC);
    f_sum     = (F + 1)'({s1_man, {GUARD_BITS{1'b0}}}) + (F + 1)'(prod >> SHIFT);
    f_frac    = f_sum[F] ? '1 : f_sum[F-1:0];
    int_part  = {k_abs, {F{1'b0}}};
    mag_next  = k_neg ? (int_part - VW'(f_frac)) : (int_part + VW'(f_frac));
  end

  logu_lzc #(
    .WIDTH     (VW),
    .CNT_WIDTH (CW)
  ) u_lzc (
    .value (s2_mag),
    .count (lz_count),
    .empty (mag_zero)
  );

  // Renormalise: shift the leading one up to the MSB, drop it, and keep the
  // next M bits (truncation). Special classes replace the packed value.
  always_comb begin
    norm_exp   = E'(EXP_OFFSET) - E'(lz_count);
    norm_mant  = M'((s2_mag << lz_count) >> (VW - 1 - M));
    packed_res = mag_zero ? '0 : {s2_neg, norm_exp, norm_mant};
    case (s2_class)
      ZERO:    res_next = NEG_INF_PAT;
      NEG:     res_next = NAN_PAT;
      INF:     res_next = POS_INF_PAT;
      NAN:     res_next = NAN_PAT;
      default: res_next = packed_res;
    endcase
  end

  // Stage valid flags; each moves only when its stage may advance, so a
  // stalled output keeps valid_o asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= valid_i;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) s3_valid <= s2_valid;
    end
  end

  // Stage data; loaded only when a valid item actually moves in, which keeps
  // res_o stable while the output is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_class <= NORMAL;
      s2_mag   <= '0;
      s2_neg   <= 1'b0;
      s2_class <= NORMAL;
      s3_res   <= '0;
    end else begin
      if (s1_ready && valid_i) begin
        s1_exp   <= in_exp;
        s1_man   <= in_man;
        s1_class <= in_class;
      end
      if (s2_ready && s1_valid) begin
        s2_mag   <= mag_next;
        s2_neg   <= k_neg;
        s2_class <= s1_class;
      end
      if (s3_ready && s2_valid) begin
        s3_res <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_logu_log2.sv
// tb_logu_log2
// Self-checking bench for logu_log2 (FP16ALT). Directed vectors carry exact
// expected bit patterns; the sweep compares against real-valued log2.
module tb_logu_log2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] op_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;

  typedef struct {
    logic [15:0] op;
    logic [15:0] expected;
    bit          exact;
    bit          check_lat;
    int          accept_cycle;
  } entry_t;

  entry_t      sb[$];
  int          check_count = 0;
  int          error_count = 0;
  int          cycle = 0;
  bit          stalled = 1'b0;
  logic [15:0] held_res;
  bit          have_last = 1'b0;
  real         last_real;
  bit          rand_done;

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  logu_log2 dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic real toReal(input logic [15:0] v);
    int  e;
    real mag;
    e = int'(v[14:7]);
    if (e == 0) return 0.0;
    mag = (1.0 + real'(int'(v[6:0])) / 128.0) * (2.0 ** (e - 127));
    return v[15] ? -mag : mag;
  endfunction

  // Size of one step of the last mantissa bit; the result is truncated so
  // it may sit up to this far below the true value.
  function automatic real ulpOf(input logic [15:0] v);
    int e;
    e = int'(v[14:7]);
    if (e == 0) return 0.0;
    return 2.0 ** (e - 134);
  endfunction

  // Present one operand and hold it until the unit takes it.
  task automatic applyStimulus(input logic [15:0] op, input logic [15:0] exp_res,
                               input bit exact, input bit lat);
    entry_t ent;
    bit     accepted = 1'b0;
    int     waited = 0;
    valid_i = 1'b1;
    op_i    = op;
    while (!accepted && waited < 100) begin
      @(negedge clk);
      if (ready_o) begin
        accepted         = 1'b1;
        ent.op           = op;
        ent.expected     = exp_res;
        ent.exact        = exact;
        ent.check_lat    = lat;
        ent.accept_cycle = cycle;
        sb.push_back(ent);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks that a
  // stalled result is held unchanged.
  real    mon_x, mon_ref, mon_r, mon_err, mon_tol;
  entry_t cur;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid_o", 32'(valid_o), 32'd1);
        checkOutput("stall_res_o", 32'(res_o), 32'(held_res));
      end
      if (valid_o && ready_i) begin
        checkOutput("pending_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          if (cur.exact) begin
            checkOutput($sformatf("result op=%h", cur.op), 32'(res_o), 32'(cur.expected));
          end else begin
            mon_x   = toReal(cur.op);
            mon_ref = $ln(mon_x) / $ln(2.0);
            mon_r   = toReal(res_o);
            mon_err = (mon_r > mon_ref) ? (mon_r - mon_ref) : (mon_ref - mon_r);
            mon_tol = 0.01 + ulpOf(res_o);
            checkOutput($sformatf("log2_tol op=%h res=%h", cur.op, res_o),
                        32'(mon_err <= mon_tol), 32'd1);
            if (have_last) begin
              checkOutput($sformatf("monotonic op=%h res=%h", cur.op, res_o),
                          32'(mon_r >= last_real), 32'd1);
            end
            have_last = 1'b1;
            last_real = mon_r;
          end
          if (cur.check_lat) begin
            checkOutput($sformatf("latency op=%h", cur.op), 32'(cycle - cur.accept_cycle), 32'd3);
          end
        end
      end
      stalled  = valid_o && !ready_i;
      held_res = res_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] dir_ops [10] = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4100, 16'h3FC0,
                                16'h0000, 16'h0001, 16'hBF80, 16'h7F80, 16'h7FC1};
  logic [15:0] dir_exp [10] = '{16'h0000, 16'h3F80, 16'hBF80, 16'h4040, 16'h3F16,
                                16'hFF80, 16'hFF80, 16'h7FC0, 16'h7F80, 16'h7FC0};
  logic [15:0] bp_ops [6] = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4100, 16'h3FC0, 16'h7F80};
  logic [15:0] bp_exp [6] = '{16'h0000, 16'h3F80, 16'hBF80, 16'h4040, 16'h3F16, 16'h7F80};

  initial begin
    logic [15:0] rop;
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = 16'h0000;
    #3;
    checkOutput("reset_valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset_res_o", 32'(res_o), 32'd0);
    checkOutput("reset_ready_o", 32'(ready_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) applyStimulus(dir_ops[i], dir_exp[i], 1'b1, 1'b1);
    valid_i = 1'b0;
    waitDrain();

    $display("[TB] backpressure");
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(bp_ops[i], bp_exp[i], 1'b1, 1'b0);
        valid_i = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        ready_i = 1'b0;
        @(negedge clk);
        checkOutput("bp_ready_o_first", 32'(ready_o), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready_o_last", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] reset mid-stream");
    applyStimulus(16'h4100, 16'h4040, 1'b1, 1'b1);
    applyStimulus(16'h3FC0, 16'h3F16, 1'b1, 1'b1);
    applyStimulus(16'h3F00, 16'hBF80, 1'b1, 1'b1);
    valid_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid_o", 32'(valid_o), 32'd0);
    checkOutput("midrst_res_o", 32'(res_o), 32'd0);
    checkOutput("midrst_ready_o", 32'(ready_o), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(16'h4000, 16'h3F80, 1'b1, 1'b1);
    valid_i = 1'b0;
    waitDrain();

    $display("[TB] random sweep");
    have_last = 1'b0;
    rand_done = 1'b0;
    fork
      begin
        rop = 16'h0080;
        while (rop < 16'h7F80) begin
          applyStimulus(rop, 16'h0000, 1'b0, 1'b0);
          rop = rop + 16'($urandom_range(1, 400));
        end
        valid_i   = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
